// File: rtl/mistura_colunas_seq.sv
// rtl/mistura_colunas_seq.sv - sequential AES forward MixColumns, COL_POR_CICLO columns per clock
// Result is copied to a dedicated output register so a partially mixed block is never visible.

module mistura_coluna (
    input  logic [31:0] coluna_i,
    output logic [31:0] coluna_o
);
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    logic [7:0] a0, a1, a2, a3;
    logic [7:0] d0, d1, d2, d3;

    always_comb begin
        a0 = coluna_i[31:24];
        a1 = coluna_i[23:16];
        a2 = coluna_i[15:8];
        a3 = coluna_i[7:0];
        d0 = xtime(a0);
        d1 = xtime(a1);
        d2 = xtime(a2);
        d3 = xtime(a3);
        coluna_o[31:24] = d0 ^ (d1 ^ a1) ^ a2 ^ a3;
        coluna_o[23:16] = a0 ^ d1 ^ (d2 ^ a2) ^ a3;
        coluna_o[15:8]  = a0 ^ a1 ^ d2 ^ (d3 ^ a3);
        coluna_o[7:0]   = (d0 ^ a0) ^ a1 ^ a2 ^ d3;
    end
endmodule

module mistura_colunas_seq #(
    parameter int COL_POR_CICLO = 1
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         entrada_valida,
    output logic         entrada_pronta,
    input  logic [127:0] bloco_entrada,
    output logic         saida_valida,
    input  logic         saida_pronta,
    output logic [127:0] bloco_saida
);
    localparam int         N      = 4 / COL_POR_CICLO;
    localparam logic [1:0] ULTIMO = 2'(N - 1);

    typedef enum logic [1:0] {
        OCIOSO,
        CALCULA,
        PRONTO
    } estado_t;

    estado_t      estado_q, estado_d;
    logic [1:0]   cont_q, cont_d;
    logic [127:0] bloco_q, bloco_d;
    logic [127:0] saida_q, saida_d;
    logic         valida_q, valida_d;

    logic [31:0]  col_in  [COL_POR_CICLO];
    logic [31:0]  col_out [COL_POR_CICLO];
    logic [127:0] misturado;

    // Columns handled this cycle: cont_q*COL_POR_CICLO .. +COL_POR_CICLO-1
    always_comb begin
        for (int i = 0; i < COL_POR_CICLO; i++) begin
            col_in[i] = bloco_q[127 - 32 * (int'(cont_q) * COL_POR_CICLO + i) -: 32];
        end
    end

    for (genvar g = 0; g < COL_POR_CICLO; g++) begin : g_coluna
        mistura_coluna u_coluna (
            .coluna_i (col_in[g]),
            .coluna_o (col_out[g])
        );
    end

    always_comb begin
        misturado = bloco_q;
        for (int i = 0; i < COL_POR_CICLO; i++) begin
            misturado[127 - 32 * (int'(cont_q) * COL_POR_CICLO + i) -: 32] = col_out[i];
        end
    end

    always_comb begin
        estado_d       = estado_q;
        cont_d         = cont_q;
        bloco_d        = bloco_q;
        saida_d        = saida_q;
        valida_d       = valida_q;
        entrada_pronta = 1'b0;
        case (estado_q)
            OCIOSO: begin
                entrada_pronta = 1'b1;
                if (entrada_valida) begin
                    bloco_d  = bloco_entrada;
                    cont_d   = 2'd0;
                    estado_d = CALCULA;
                end
            end
            CALCULA: begin
                bloco_d = misturado;
                cont_d  = cont_q + 2'd1;
                if (cont_q == ULTIMO) begin
                    cont_d   = 2'd0;
                    estado_d = PRONTO;
                end
            end
            PRONTO: begin
                // First PRONTO cycle publishes the finished block; handshake only after that.
                if (!valida_q) begin
                    saida_d  = bloco_q;
                    valida_d = 1'b1;
                end else if (saida_pronta) begin
                    valida_d = 1'b0;
                    estado_d = OCIOSO;
                end
            end
            default: begin
                estado_d = OCIOSO;
                valida_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q <= OCIOSO;
            cont_q   <= 2'd0;
            bloco_q  <= '0;
            saida_q  <= '0;
            valida_q <= 1'b0;
        end else begin
            estado_q <= estado_d;
            cont_q   <= cont_d;
            bloco_q  <= bloco_d;
            saida_q  <= saida_d;
            valida_q <= valida_d;
        end
    end

    assign saida_valida = valida_q;
    assign bloco_saida  = saida_q;
endmodule

// File: tb/tb_mistura_colunas_seq.sv
// tb/tb_mistura_colunas_seq.sv - bench for mistura_colunas_seq with COL_POR_CICLO 1, 2 and 4
// Expected blocks come from a matrix-over-GF(2^8) model; inverse matrix checks round trips.

module tb_mistura_colunas_seq;
    logic         clk;
    logic         rst;
    logic         ev [3];
    logic         ep [3];
    logic [127:0] bi [3];
    logic         sv [3];
    logic         sp [3];
    logic [127:0] bo [3];

    int vectors    = 0;
    int miscompares = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        mistura_colunas_seq #(.COL_POR_CICLO((g == 0) ? 1 : ((g == 1) ? 2 : 4))) dut (
            .clock          (clk),
            .reset          (rst),
            .entrada_valida (ev[g]),
            .entrada_pronta (ep[g]),
            .bloco_entrada  (bi[g]),
            .saida_valida   (sv[g]),
            .saida_pronta   (sp[g]),
            .bloco_saida    (bo[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [127:0] mix_model(input logic [127:0] b, input bit inv);
        logic [7:0]   coef [4];
        logic [127:0] r;
        logic [7:0]   acc;
        if (inv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
        r = '0;
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++)
                    acc = acc ^ gmul(coef[(j - row + 4) % 4], b[127 - 8 * (4 * c + j) -: 8]);
                r[127 - 8 * (4 * c + row) -: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic int cpc(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Returns #1 after the acceptance edge.
    task automatic submit(input int k, input logic [127:0] blk);
        int n;
        n = 0;
        bi[k] = blk;
        ev[k] = 1'b1;
        while (ep[k] !== 1'b1 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("accept_wait", 128'(n < 50), 128'd1);
        @(posedge clk); #1;
        ev[k] = 1'b0;
        bi[k] = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic await_result(input int k, input logic [127:0] exp, input string tag);
        int lat;
        lat = 0;
        while (sv[k] !== 1'b1 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
            bi[k] = {$urandom, $urandom, $urandom, $urandom};
            sp[k] = 1'($urandom_range(0, 1));
        end
        sp[k] = 1'b0;
        check({tag, "_latency"}, 128'(lat), 128'(4 / cpc(k) + 1));
        check({tag, "_data"}, bo[k], exp);
    endtask

    task automatic consume(input int k);
        sp[k] = 1'b1;
        @(posedge clk); #1;
        sp[k] = 1'b0;
        check("consume_valid_low", 128'(sv[k]), 128'd0);
        check("consume_ready_high", 128'(ep[k]), 128'd1);
    endtask

    initial begin
        logic [127:0] v, va, vb, held;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            ev[k] = 1'b0;
            sp[k] = 1'b0;
            bi[k] = '0;
        end

        @(posedge clk); #2;
        for (int k = 0; k < 3; k++) begin
            check("reset_data", bo[k], '0);
            check("reset_valid", 128'(sv[k]), 128'd0);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) check("release_ready", 128'(ep[k]), 128'd1);

        v = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
        submit(0, v);
        await_result(0, 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6, "fips");
        consume(0);

        v = 128'h6e4f6e4947655a494a7a71707f41426e;
        for (int k = 0; k < 3; k++) begin
            submit(k, v);
            await_result(k, mix_model(v, 1'b0), "vec2");
            check("vec2_inverse", mix_model(bo[k], 1'b1), v);
            consume(k);
        end

        va = {$urandom, $urandom, $urandom, $urandom};
        vb = {$urandom, $urandom, $urandom, $urandom};
        submit(0, va);
        await_result(0, mix_model(va, 1'b0), "bp_first");
        held  = bo[0];
        bi[0] = vb;
        ev[0] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_data_stable", bo[0], held);
            check("bp_valid_held", 128'(sv[0]), 128'd1);
            check("bp_not_ready", 128'(ep[0]), 128'd0);
        end
        sp[0] = 1'b1;
        @(posedge clk); #1;
        sp[0] = 1'b0;
        check("simul_consumed", 128'(sv[0]), 128'd0);
        check("simul_not_same_edge", 128'(ep[0]), 128'd1);
        check("simul_data_kept", bo[0], held);
        @(posedge clk); #1;
        check("simul_accepted_next", 128'(ep[0]), 128'd0);
        ev[0] = 1'b0;
        bi[0] = {$urandom, $urandom, $urandom, $urandom};
        await_result(0, mix_model(vb, 1'b0), "bp_second");
        consume(0);

        v = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
        submit(0, v);
        @(posedge clk); #1;
        @(posedge clk); #2;
        rst = 1'b1;
        #1;
        check("rst_mid_data", bo[0], '0);
        check("rst_mid_valid", 128'(sv[0]), 128'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check("rst_mid_ready", 128'(ep[0]), 128'd1);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("rst_no_stale_valid", 128'(sv[0]), 128'd0);
        end
        submit(0, v);
        await_result(0, 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff, "rst_resubmit");
        consume(0);

        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 15; i++) begin
                v = {$urandom, $urandom, $urandom, $urandom};
                submit(k, v);
                await_result(k, mix_model(v, 1'b0), "rand");
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk); #1;
                end
                check("rand_hold", bo[k], mix_model(v, 1'b0));
                consume(k);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
